rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (A3/wd3/we) between NREQ writeback requesters, e.g. ALU writeback and load/CSR writeback.
- Each requester uses a valid/ready handshake. Grants rotate round-robin, and the winner is registered onto the RF write port one cycle later.
- Provides combinational pending-write hazard flags for the two RF read addresses (A1/A2) so decode can stall.

Parameters:
- NREQ, 2, number of writeback requesters (2..4)
- XLEN, 32, register data width
- AW, 5, register address width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  requester i has a write pending
- req_ready  output  NREQ  requester i granted this cycle
- req_addr  input  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  input  NREQ*XLEN  write data, requester i at bits [i*XLEN +: XLEN]
- wb_hold  input  1  pipeline freeze; suppresses all grants
- rf_A3  output  AW  RF write address (registered)
- rf_wd3  output  XLEN  RF write data (registered)
- rf_we  output  1  RF write enable (registered)
- rd_A1  input  AW  RF read port 1 address being decoded
- rd_A2  input  AW  RF read port 2 address being decoded
- hz1  output  1  pending write to rd_A1
- hz2  output  1  pending write to rd_A2

Behaviour:
- Reset (async, asserted): rf_we=0, rf_A3=0, rf_wd3=0, round-robin pointer ptr=NREQ-1, so requester 0 has first priority after reset. req_ready is 0 while reset is high.
- Grant rule: combinational. When wb_hold=0, exactly one req_ready bit is high: the first requester with req_valid=1 searching ptr+1, ptr+2, … modulo NREQ. If no requester is valid, or wb_hold=1, all req_ready bits are 0.
- Handshake: a transfer occurs on valid&ready. A requester holds valid/addr/data stable until its transfer. ready may depend on valid; valid must not depend on ready.
- Pointer: on a transfer by requester g, ptr<=g at the clock edge. With no transfer, ptr holds.
- Latency: a transfer in cycle N gives rf_we=1 with rf_A3/rf_wd3 = the winner's addr/data during cycle N+1. The RF commits at the end of N+1. With no transfer in cycle N, rf_we=0 in N+1 and rf_A3/rf_wd3 hold their previous values.
- x0: a request with addr=0 is accepted normally (ready, pointer advances) but produces rf_we=0 in N+1.
- Throughput: one write per cycle sustained, with no bubble between back-to-back grants.
- Fairness: with all NREQ valid continuously, grants cycle 0,1,…,NREQ-1. A valid requester is granted within NREQ non-hold cycles.
- wb_hold: grants stop in the same cycle. rf_we drops in the next cycle. ptr is frozen. Pending requests are unaffected.
- Hazard flags (combinational):
  - hz1 = (rd_A1!=0) & ((rf_we & rf_A3==rd_A1) | OR over i of (req_valid[i] & req_addr[i]==rd_A1)).
  - hz2 is the same using rd_A2.
  - x0 never hazards.
- Reset mid-operation: an in-flight registered write is discarded (rf_we=0). Requesters keep valid asserted, so nothing is lost. Arbitration restarts at requester 0 after reset deasserts.
- Simultaneous events: wb_hold overrides all valids. A new request arriving in the same cycle as another's grant waits its turn per ptr.

Decomposition:
- rf_pkg holds AW, XLEN, the typedefs rf_addr_t (logic [AW-1:0]) and rf_data_t (logic [XLEN-1:0]), and the constant REG_ZERO='0. The RF interface and testbench import the same package.
- One sub-module, rr_arbiter: parameter N; inputs req[N], en, ptr; output one-hot gnt[N]. It is purely combinational, with the rotate-priority search. The pointer register and output stage live in rf_wb_arbiter.

Test Plan:
- Reset: hold reset 3 cycles with req_valid=2'b11 -> req_ready=0, rf_we=0, rf_A3=0, rf_wd3=0. The first cycle after release grants requester 0.
- Single requester: req0 addr=5, data=0xDEADBEEF valid 1 cycle -> req_ready[0]=1 in the same cycle; next cycle rf_we=1, rf_A3=5, rf_wd3=0xDEADBEEF; the cycle after, rf_we=0.
- Contention: both valid continuously (req0 addr=1/data=0x11, req1 addr=2/data=0x22) for 4 cycles -> grants 0,1,0,1; rf_A3 sequence 1,2,1,2 one cycle later with rf_we=1 throughout.
- x0 drop: req1 addr=0, data=0x1234 -> req_ready[1]=1, rf_we=0 next cycle, ptr=1, so a subsequent req0 is granted next.
- Hold and hazard: req0 addr=7 valid with wb_hold=1, rd_A1=7, rd_A2=0 -> req_ready=0, hz1=1, hz2=0. Release hold -> grant. Next cycle hz1 stays 1 via rf_we/rf_A3=7, then clears to 0.
- Async reset mid-write: assert reset between clock edges while rf_we=1 -> rf_we=0 immediately. After release the held req1 is still pending, and it is granted once req0 is not valid.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the writeback path and its users.
package rf_pkg;

    localparam int AW   = 5;
    localparam int XLEN = 32;

    typedef logic [AW-1:0]   rf_addr_t;
    typedef logic [XLEN-1:0] rf_data_t;

    localparam rf_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: searches ptr+1, ptr+2, ... modulo N
// and grants the first requester found, one-hot.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between NREQ writeback requesters
// with round-robin grants, a registered write stage, and read-address hazard flags.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = rf_pkg::XLEN,
    parameter int AW   = rf_pkg::AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 wb_hold,
    output logic [AW-1:0]        rf_A3,
    output logic [XLEN-1:0]      rf_wd3,
    output logic                 rf_we,
    input  logic [AW-1:0]        rd_A1,
    input  logic [AW-1:0]        rd_A2,
    output logic                 hz1,
    output logic                 hz2
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: a write transfers when req_valid[i] & req_ready[i]. The requester
    // holds valid/addr/data stable until then; ready depends on valid, never the reverse.

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_A3_q, rf_A3_d;
    logic [XLEN-1:0] rf_wd3_q, rf_wd3_d;
    logic [NREQ-1:0] gnt;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .req (req_valid),
        .en  (~wb_hold & ~reset),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign rf_we     = rf_we_q;
    assign rf_A3     = rf_A3_q;
    assign rf_wd3    = rf_wd3_q;

    // x0 writes are accepted and advance the pointer but never reach the RF.
    always_comb begin
        ptr_d    = ptr_q;
        rf_we_d  = 1'b0;
        rf_A3_d  = rf_A3_q;
        rf_wd3_d = rf_wd3_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                ptr_d = PW'(i);
                if (req_addr[i*AW +: AW] != REG_ZERO) begin
                    rf_we_d  = 1'b1;
                    rf_A3_d  = req_addr[i*AW +: AW];
                    rf_wd3_d = req_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= PW'(NREQ - 1);
            rf_we_q  <= 1'b0;
            rf_A3_q  <= '0;
            rf_wd3_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rf_we_q  <= rf_we_d;
            rf_A3_q  <= rf_A3_d;
            rf_wd3_q <= rf_wd3_d;
        end
    end

    // A read address hazards against the write in flight and every pending request.
    always_comb begin
        hz1 = 1'b0;
        hz2 = 1'b0;
        if (rd_A1 != REG_ZERO) begin
            if (rf_we_q && rf_A3_q == rd_A1) hz1 = 1'b1;
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_addr[i*AW +: AW] == rd_A1) hz1 = 1'b1;
        end
        if (rd_A2 != REG_ZERO) begin
            if (rf_we_q && rf_A3_q == rd_A2) hz2 = 1'b1;
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_addr[i*AW +: AW] == rd_A2) hz2 = 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized run
// compared against a behavioural model of grants, writes and hazards.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int NREQ = 2;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 wb_hold;
    logic [AW-1:0]        rf_A3;
    logic [XLEN-1:0]      rf_wd3;
    logic                 rf_we;
    logic [AW-1:0]        rd_A1, rd_A2;
    logic                 hz1, hz2;

    int checks = 0;
    int errors = 0;

    // Model state: last winner and the expected registered write port.
    int       m_last;
    logic     m_we;
    rf_addr_t m_a3;
    rf_data_t m_wd;

    rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wb_hold   (wb_hold),
        .rf_A3     (rf_A3),
        .rf_wd3    (rf_wd3),
        .rf_we     (rf_we),
        .rd_A1     (rd_A1),
        .rd_A2     (rd_A2),
        .hz1       (hz1),
        .hz2       (hz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_last = NREQ - 1;
        m_we   = 1'b0;
        m_a3   = '0;
        m_wd   = '0;
    endtask

    function automatic int exp_gnt();
        int idx;
        if (reset || wb_hold) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        int g;
        r = '0;
        g = exp_gnt();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_hz(input rf_addr_t a);
        if (a == REG_ZERO) return 1'b0;
        if (m_we && m_a3 == a) return 1'b1;
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_addr[i*AW +: AW] == a) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock and update the model; returns with time 1 past the edge.
    task automatic clk_edge(output int g);
        rf_addr_t a;
        g = exp_gnt();
        a = (g >= 0) ? req_addr[g*AW +: AW] : REG_ZERO;
        @(posedge clk);
        if (reset) model_reset();
        else if (g >= 0) begin
            m_last = g;
            m_we   = (a != REG_ZERO);
            if (m_we) begin
                m_a3 = a;
                m_wd = req_data[g*XLEN +: XLEN];
            end
        end else m_we = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        int g;
        reset = 1'b1; wb_hold = 1'b0; rd_A1 = '0; rd_A2 = '0;
        req_valid = 2'b11; req_addr = {5'd2, 5'd1}; req_data = {32'h22, 32'h11};
        model_reset();
        repeat (3) clk_edge(g);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", rf_we); end
        checks++; if (rf_A3 !== '0) begin errors++; $display("FAIL reset_A3 got %0d exp 0", rf_A3); end
        checks++; if (rf_wd3 !== '0) begin errors++; $display("FAIL reset_wd3 got %h exp 0", rf_wd3); end
        reset = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b exp 01", req_ready); end
        clk_edge(g);
        req_valid = 2'b00;
        checks++; if (rf_we !== 1'b1 || rf_A3 !== 5'd1) begin errors++; $display("FAIL reset_first_write got we=%b A3=%0d exp we=1 A3=1", rf_we, rf_A3); end
        clk_edge(g);
    endtask

    task automatic test_single();
        int g;
        req_valid = 2'b01; req_addr[0 +: AW] = 5'd5; req_data[0 +: XLEN] = 32'hDEADBEEF;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
        clk_edge(g);
        req_valid = 2'b00;
        checks++; if (rf_we !== 1'b1 || rf_A3 !== 5'd5 || rf_wd3 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write got we=%b A3=%0d wd3=%h exp we=1 A3=5 wd3=deadbeef", rf_we, rf_A3, rf_wd3);
        end
        clk_edge(g);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_drop got %b exp 0", rf_we); end
    endtask

    task automatic test_contention();
        int g;
        logic [NREQ-1:0] prev;
        req_valid = 2'b11; req_addr = {5'd2, 5'd1}; req_data = {32'h22, 32'h11};
        prev = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (req_ready !== exp_ready() || req_ready === prev) begin
                errors++; $display("FAIL contention_grant c=%0d got %b exp %b prev %b", c, req_ready, exp_ready(), prev);
            end
            prev = req_ready;
            clk_edge(g);
            checks++; if (rf_we !== 1'b1 || rf_A3 !== rf_addr_t'(g + 1) || rf_wd3 !== rf_data_t'(32'h11 * (g + 1))) begin
                errors++; $display("FAIL contention_write c=%0d got we=%b A3=%0d wd3=%h winner %0d", c, rf_we, rf_A3, rf_wd3, g);
            end
        end
        req_valid = 2'b00;
        clk_edge(g);
    endtask

    task automatic test_x0();
        int g;
        req_valid = 2'b10; req_addr = {5'd0, 5'd3}; req_data = {32'h1234, 32'h33};
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL x0_ready got %b exp 10", req_ready); end
        clk_edge(g);
        req_valid = 2'b11; #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b exp 0", rf_we); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL x0_next_grant got %b exp 01", req_ready); end
        clk_edge(g);
        req_valid = 2'b10; req_addr[AW +: AW] = 5'd9;
        checks++; if (rf_we !== 1'b1 || rf_A3 !== 5'd3) begin errors++; $display("FAIL x0_follow_write got we=%b A3=%0d exp we=1 A3=3", rf_we, rf_A3); end
        clk_edge(g);
        req_valid = 2'b00;
        clk_edge(g);
    endtask

    task automatic test_hold_hazard();
        int g;
        req_valid = 2'b01; req_addr[0 +: AW] = 5'd7; req_data[0 +: XLEN] = 32'h77;
        wb_hold = 1'b1; rd_A1 = 5'd7; rd_A2 = 5'd0;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL hold_ready got %b exp 00", req_ready); end
        checks++; if (hz1 !== 1'b1 || hz2 !== 1'b0) begin errors++; $display("FAIL hold_hz got hz1=%b hz2=%b exp 1 0", hz1, hz2); end
        clk_edge(g);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL hold_we got %b exp 0", rf_we); end
        wb_hold = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL hold_release_grant got %b exp 01", req_ready); end
        clk_edge(g);
        req_valid = 2'b00; #1;
        checks++; if (hz1 !== 1'b1 || rf_we !== 1'b1 || rf_A3 !== 5'd7) begin
            errors++; $display("FAIL hold_inflight_hz got hz1=%b we=%b A3=%0d exp 1 1 7", hz1, rf_we, rf_A3);
        end
        clk_edge(g);
        checks++; if (hz1 !== 1'b0) begin errors++; $display("FAIL hold_hz_clear got %b exp 0", hz1); end
        rd_A1 = '0;
    endtask

    task automatic test_async_reset();
        int g;
        req_valid = 2'b11; req_addr = {5'd6, 5'd4}; req_data = {32'h66, 32'h44};
        clk_edge(g);
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL areset_pre_we got %b exp 1", rf_we); end
        #2 reset = 1'b1; #1;
        model_reset();
        checks++; if (rf_we !== 1'b0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL areset_async got we=%b ready=%b exp 0 00", rf_we, req_ready);
        end
        clk_edge(g);
        reset = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL areset_restart got %b exp 01", req_ready); end
        clk_edge(g);
        req_valid = 2'b10; #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL areset_req1_pending got %b exp 10", req_ready); end
        clk_edge(g);
        req_valid = 2'b00;
        checks++; if (rf_we !== 1'b1 || rf_A3 !== 5'd6 || rf_wd3 !== 32'h66) begin
            errors++; $display("FAIL areset_req1_write got we=%b A3=%0d wd3=%h exp 1 6 66", rf_we, rf_A3, rf_wd3);
        end
        clk_edge(g);
    endtask

    task automatic test_random();
        int g;
        int wait_c[NREQ];
        g = -1;
        for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && g == i) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                    req_data[i*XLEN +: XLEN] = $urandom;
                end
            end
            wb_hold = ($urandom_range(0, 4) == 0);
            rd_A1 = AW'($urandom_range(0, 7));
            rd_A2 = AW'($urandom_range(0, 7));
            #1;
            checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready c=%0d got %b exp %b", c, req_ready, exp_ready()); end
            checks++; if (hz1 !== exp_hz(rd_A1) || hz2 !== exp_hz(rd_A2)) begin
                errors++; $display("FAIL rand_hz c=%0d got %b%b exp %b%b", c, hz1, hz2, exp_hz(rd_A1), exp_hz(rd_A2));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !wb_hold) wait_c[i]++;
                if (req_ready[i]) begin
                    checks++; if (wait_c[i] > NREQ) begin errors++; $display("FAIL rand_fairness req%0d waited %0d max %0d", i, wait_c[i], NREQ); end
                    wait_c[i] = 0;
                end
            end
            clk_edge(g);
            checks++; if (rf_we !== m_we || (m_we && (rf_A3 !== m_a3 || rf_wd3 !== m_wd))) begin
                errors++; $display("FAIL rand_write c=%0d got we=%b A3=%0d wd3=%h exp we=%b A3=%0d wd3=%h", c, rf_we, rf_A3, rf_wd3, m_we, m_a3, m_wd);
            end
        end
        req_valid = '0; wb_hold = 1'b0;
        clk_edge(g);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_hold_hazard();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
